// File: rtl/led_matrix_frame_capture.sv
// Rebuilds 16x16 LED matrix frames from the multiplexed col_sel/col_data scan and
// publishes them over valid/ready. Optional FRAME_DIFF_EN adds a per-publish bit-diff count.
module led_matrix_frame_capture #(
   parameter int STABLE_CYCLES = 4,
   parameter int COLS          = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [3:0]           col_sel,
   input  logic [15:0]          col_data,
   output logic [COLS*16-1:0]   frame_out,
   output logic                 frame_valid,
   input  logic                 frame_ready,
   output logic                 scan_error,
   output logic [7:0]           overflow_cnt,
   output logic                 sync_locked
`ifdef FRAME_DIFF_EN
   ,
   output logic [8:0]           diff_count
`endif
);

   localparam int EW = $clog2(COLS);

   typedef enum logic {SYNC, CAPTURE} state_t;

   state_t              state, state_n;
   logic [EW-1:0]       expect_col, expect_n;
   logic [3:0]          sel_m, sel_s, sel_q;
   logic [15:0]         dat_m, dat_s, dat_q;
   logic [7:0]          stab_cnt;
   logic [COLS*16-1:0]  shadow;
   logic                same, accept, wr_en, clr, err_set, done, pub_pend;

   // Accept fires once, on the cycle the counter would step onto STABLE_CYCLES.
   assign same   = ({sel_s, dat_s} == {sel_q, dat_q});
   assign accept = same && (stab_cnt == 8'(STABLE_CYCLES - 1));
   assign sync_locked = (state == CAPTURE);

   always_comb begin
      state_n  = state;
      expect_n = expect_col;
      wr_en    = 1'b0;
      clr      = 1'b0;
      err_set  = 1'b0;
      done     = 1'b0;
      if (accept) begin
         case (state)
            SYNC: begin
               if (sel_s == '0) begin
                  wr_en    = 1'b1;
                  expect_n = EW'(1);
                  state_n  = CAPTURE;
               end
            end
            CAPTURE: begin
               if (sel_s == expect_col) begin
                  wr_en = 1'b1;
                  if (expect_col == EW'(COLS - 1)) begin
                     done     = 1'b1;
                     state_n  = SYNC;
                     expect_n = '0;
                  end else begin
                     expect_n = expect_col + EW'(1);
                  end
               end else begin
                  err_set = 1'b1;
                  clr     = 1'b1;
                  // An out-of-order column 0 is taken as the start of a fresh frame.
                  if (sel_s == '0) begin
                     wr_en    = 1'b1;
                     expect_n = EW'(1);
                  end else begin
                     state_n  = SYNC;
                     expect_n = '0;
                  end
               end
            end
            default: state_n = SYNC;
         endcase
      end
   end

`ifdef FRAME_DIFF_EN
   logic [COLS*16-1:0] diff_vec;
   logic [8:0]         diff_pop;
   assign diff_vec = shadow ^ frame_out;
   always_comb begin
      diff_pop = '0;
      for (int i = 0; i < COLS*16; i++) diff_pop = diff_pop + 9'(diff_vec[i]);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_m        <= '0;
         sel_s        <= '0;
         sel_q        <= '0;
         dat_m        <= '0;
         dat_s        <= '0;
         dat_q        <= '0;
         stab_cnt     <= '0;
         state        <= SYNC;
         expect_col   <= '0;
         shadow       <= '0;
         pub_pend     <= 1'b0;
         frame_out    <= '0;
         frame_valid  <= 1'b0;
         scan_error   <= 1'b0;
         overflow_cnt <= '0;
`ifdef FRAME_DIFF_EN
         diff_count   <= '0;
`endif
      end else begin
         sel_m <= col_sel;
         sel_s <= sel_m;
         sel_q <= sel_s;
         dat_m <= col_data;
         dat_s <= dat_m;
         dat_q <= dat_s;
         if (!same)
            stab_cnt <= '0;
         else if (stab_cnt != 8'(STABLE_CYCLES))
            stab_cnt <= stab_cnt + 8'd1;

         state      <= state_n;
         expect_col <= expect_n;
         pub_pend   <= done;
         if (err_set) scan_error <= 1'b1;
         if (clr)     shadow     <= '0;
         if (wr_en)   shadow[{sel_s, 4'b0000} +: 16] <= dat_s;

         // Publish wins over a simultaneous consume; otherwise a pending frame is dropped.
         if (pub_pend && (!frame_valid || frame_ready)) begin
            frame_out   <= shadow;
            frame_valid <= 1'b1;
`ifdef FRAME_DIFF_EN
            diff_count  <= diff_pop;
`endif
         end else begin
            if (pub_pend && overflow_cnt != 8'hFF) overflow_cnt <= overflow_cnt + 8'd1;
            if (frame_ready) frame_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/led_matrix_frame_capture.md
Name: led_matrix_frame_capture

Overview:
- Receive-side decoder for the 16x16 LED matrix scan interface (col_sel / col_data) driven by the matrix driver.
- Samples the multiplexed scan, rebuilds the 256-bit frame and publishes each complete frame over a valid/ready handshake.
- Used for on-board self-test and loopback verification of the display path. Typical consumers are score/frame checkers and debug readout.

Parameters:
- STABLE_CYCLES, default 4: number of consecutive clk cycles col_sel and col_data must hold unchanged before the column is accepted. Range 1..255.
- COLS, default 16: number of scan columns. Fixed at 16; the parameter exists for documentation and assertions only.

Ports:
- clk, input, 1: system clock (50 MHz). The scan inputs are asynchronous to it.
- rst, input, 1: synchronous, active-high reset.
- col_sel, input, 4: active column index from the scan.
- col_data, input, 16: pixel data for the active column. Bit i is row i.
- frame_out, output, 256: last published frame. Bit col*16+i is col_data[i] of column col.
- frame_valid, output, 1: frame_out holds an unconsumed frame.
- frame_ready, input, 1: consumer accepts the frame.
- scan_error, output, 1: sticky flag for a column-sequence violation.
- overflow_cnt, output, 8: count of frames dropped because the previous frame was still pending. Saturates at 255.
- sync_locked, output, 1: high while in state CAPTURE.

Behaviour:
- Input sync: col_sel and col_data pass through a 2-flop synchronizer. All logic below uses the synchronized values.
- Stability filter:
  - stab_cnt resets to 0 whenever the synchronized {col_sel, col_data} differs from its value one cycle earlier. Otherwise it increments, saturating at STABLE_CYCLES.
  - A column is accepted in the cycle stab_cnt first reaches STABLE_CYCLES. Exactly one accept occurs per stable period; re-arm happens only on the next input change.
  - A column whose inputs remain unchanged across two scan slots (same sel, same data) is accepted once. The scan driver guarantees that col_sel changes every slot.
- State machine, 2 states:
  - SYNC (reset state): ignore accepts with col_sel != 0. An accept with col_sel == 0 writes column 0 into the shadow buffer, sets expect = 1 and moves to CAPTURE.
  - CAPTURE:
    - An accept with col_sel == expect writes shadow[expect*16 +: 16] and increments expect.
    - An accept with col_sel != expect sets scan_error and clears the shadow buffer.
      - If that col_sel == 0: treat it as a new frame start (write column 0, expect = 1, stay in CAPTURE).
      - Otherwise: go to SYNC.
    - Accepting column 15 completes the frame; the next state is SYNC with expect cleared.
- Publish on completion, in the cycle after the column-15 write:
  - If frame_valid == 0, or frame_ready == 1 in that same cycle: load frame_out from the shadow buffer (with column 15 included) and set frame_valid = 1. Simultaneous consume and publish counts as a publish, not an overflow.
  - Otherwise: keep the old frame_out and increment overflow_cnt (saturating).
- Handshake:
  - frame_valid stays high until a cycle with frame_ready == 1, then clears on the next edge unless a publish occurs in that same cycle.
  - frame_out never changes while frame_valid == 1 && frame_ready == 0.
- Reset: takes effect on the next clk edge, including mid-frame. It clears frame_out, frame_valid, scan_error, overflow_cnt, shadow, expect, stab_cnt and the synchronizers; state = SYNC; sync_locked = 0.
- scan_error clears only on rst.
- Latency: 2 sync cycles + STABLE_CYCLES per column + 1 publish cycle from column-15 acceptance to frame_valid.

Optional Feature:
- Macro FRAME_DIFF_EN.
- When defined:
  - Adds output diff_count [8:0].
  - On each publish, it is loaded with the popcount of (new frame XOR previous frame_out). A 9-bit width is enough because the maximum count is 256.
  - It is reset to 0 and holds its value between publishes.
  - The popcount may be pipelined, but diff_count must be valid in the same cycle frame_valid rises.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Clean scan, STABLE_CYCLES = 4: drive columns 0..15 with col_data = 16'h0001 << col, each held 10 cycles -> one frame_valid. Bit col*16+col of frame_out = 1, all other bits 0. scan_error = 0.
- Backpressure: frame_ready = 0 while 3 full frames arrive -> first frame held unchanged, overflow_cnt = 2. Raising frame_ready clears frame_valid next cycle.
- Sequence error: scan 0,1,2,5 -> scan_error = 1, state = SYNC, no publish. Next clean 0..15 scan -> valid frame, scan_error still 1.
- Glitch rejection: col_data toggles every 2 cycles for 20 cycles in column 3, then holds 16'hABCD -> frame_out[63:48] = 16'hABCD.
- Reset mid-frame: assert rst after column 7 -> all outputs 0 next edge. Columns 8..15 afterwards produce no publish.
- FRAME_DIFF_EN: all-zeros frame followed by a frame with column 0 = 16'hFFFF -> diff_count = 16. Identical repeat frame -> diff_count = 0.
